saber_bout_referee: RTL and testbench
=====================================

Name: saber_bout_referee

Overview:
- Per-frame referee FSM that sequences saber-contact evaluation for a two-player fencing bout.
- On each new-frame strobe it latches both players' saber-tip and body coordinates.
- It time-multiplexes one internal Manhattan-distance comparator across three checks: saber clash, P1 touch and P2 touch.
- It then resolves parries, touches and doubles, updates scores, enforces a post-touch lockout and flags match end. It sits between the pose/tracking pipeline and the score/HUD renderer.

Parameters:
- HIT_RADIUS, 30: max |dx|+|dy| (pixels) from a saber tip to the opponent body point that counts as a touch.
- PARRY_RADIUS, 30: max |dx|+|dy| between the two saber tips that counts as a clash.
- LOCKOUT_FRAMES, 30: number of new_frame_in strobes ignored after any reported event.
- WIN_SCORE, 5: score that ends the match (1..15).

Ports:
- clk_pixel_in  in  1  pixel clock.
- rst_in  in  1  synchronous active-high reset.
- new_frame_in  in  1  one-cycle strobe; start evaluation.
- p1_blocking_in  in  1  P1 in guard/block pose.
- p2_blocking_in  in  1  P2 in guard/block pose.
- p1_saber_x_in  in  11  P1 saber tip x.
- p1_saber_y_in  in  10  P1 saber tip y.
- p1_body_x_in  in  11  P1 body target x.
- p1_body_y_in  in  10  P1 body target y.
- p2_saber_x_in, p2_saber_y_in, p2_body_x_in, p2_body_y_in  in  11/10/11/10  P2 equivalents.
- busy_out  out  1  FSM not in IDLE/OVER.
- event_valid_out  out  1  one-cycle pulse; event_code_out is valid.
- event_code_out  out  2  0 = parry, 1 = P1 touch, 2 = P2 touch, 3 = double.
- p1_score_out  out  4  P1 score.
- p2_score_out  out  4  P2 score.
- lockout_out  out  1  high while post-event lockout is active.
- match_over_out  out  1  sticky high once either score reaches WIN_SCORE.

Behaviour:
- **Clock and reset.** Single clock domain: clk_pixel_in. Reset is synchronous, active-high, on rst_in.
- **Reset values.** All outputs 0. FSM goes to IDLE. Lockout counter is 0. Reset takes priority in any state, including mid-check and OVER.
- **States:** IDLE, CHK_CLASH, CHK_P1, CHK_P2, DECIDE, LOCKOUT, OVER.
- **IDLE.** If new_frame_in is high: latch all 8 coordinates and both blocking bits, then go to CHK_CLASH.
- **CHK_CLASH / CHK_P1 / CHK_P2.** One comparator use per cycle. Operand pairs are:
  - CHK_CLASH: (p1 saber, p2 saber), result stored as clash.
  - CHK_P1: (p1 saber, p2 body), result stored as h1.
  - CHK_P2: (p2 saber, p1 body), result stored as h2.
- **Comparator arithmetic.**
  - |dx| is 11 bits and |dy| is 10 bits, each formed as larger minus smaller (no signed wrap).
  - The sum is zero-extended to 12 bits; no overflow is possible.
  - Hit if sum <= radius; equality counts as a hit.
- **DECIDE, touch validity.**
  - v1 = h1 && !(p2_blocking && clash).
  - v2 = h2 && !(p1_blocking && clash).
- **DECIDE, event selection.**
  - v1 && v2: code 3, no score change.
  - v1 only: code 1, p1_score += 1.
  - v2 only: code 2, p2_score += 1.
  - Neither valid, but clash && (p1_blocking || p2_blocking): code 0.
  - Otherwise: no event; return to IDLE.
- **Event outputs.** Registered: event_valid_out pulses high for exactly one cycle, 5 cycles after the cycle in which new_frame_in was sampled. event_code_out and the updated scores appear in that same cycle and the scores hold afterwards. event_code_out holds its last value when no event is valid.
- **Scores.** Saturate at WIN_SCORE. If a score reaches WIN_SCORE, go to OVER instead of LOCKOUT. Otherwise any event goes to LOCKOUT with the counter loaded with LOCKOUT_FRAMES.
- **LOCKOUT.**
  - lockout_out = 1.
  - Each new_frame_in decrements the counter.
  - The strobe that makes the counter 0 returns the FSM to IDLE; that strobe itself is not evaluated.
  - If LOCKOUT_FRAMES = 0, bypass LOCKOUT and go straight to IDLE.
- **OVER.** match_over_out = 1. Ignores all inputs until reset.
- **new_frame_in while busy** (CHK_*/DECIDE) is ignored, not queued.
- **Latched data.** Coordinates are latched once per evaluation; input changes during checks have no effect.
- **busy_out** is high in CHK_*, DECIDE and LOCKOUT.

Test Plan:
- **Clean P1 touch.** Reset, new_frame; p1 saber (100,100), p2 body (120,105), sabers 200 apart, no blocking -> 5 cycles later event_valid_out=1 for 1 cycle, code 1, p1_score=1; lockout_out=1 for 30 strobes, strobe 30 not evaluated.
- **Parry.** Same geometry, p2_blocking=1, p2 saber at (110,110) (distance 20) -> code 0, scores unchanged, lockout entered.
- **Radius boundary.** Distance exactly 30 -> touch. Distance 31 -> no event, FSM back to IDLE, no lockout.
- **Double touch.** h1 and h2 both within radius, no blocking -> code 3, both scores unchanged.
- **Match end.** Drive 5 P1 touches (LOCKOUT_FRAMES=2) -> p1_score=5, match_over_out=1; further frames produce no events; rst_in clears everything.
- **Reset and busy behaviour.** Assert rst_in during CHK_P1 -> next cycle IDLE, all outputs 0, no event pulse. Also extra new_frame_in during CHK_* is ignored.

Source files
------------

// File: rtl/saber_bout_referee.sv
// Saber bout referee: latches both players' poses on each frame strobe, runs one
// shared Manhattan-distance comparator over the clash, P1-touch and P2-touch checks,
// then resolves parry / touch / double, keeps score, and enforces post-event lockout.
module saber_bout_referee #(
    parameter int HIT_RADIUS     = 30,
    parameter int PARRY_RADIUS   = 30,
    parameter int LOCKOUT_FRAMES = 30,
    parameter int WIN_SCORE      = 5
) (
    input  logic        clk_pixel_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic        p1_blocking_in,
    input  logic        p2_blocking_in,
    input  logic [10:0] p1_saber_x_in,
    input  logic [9:0]  p1_saber_y_in,
    input  logic [10:0] p1_body_x_in,
    input  logic [9:0]  p1_body_y_in,
    input  logic [10:0] p2_saber_x_in,
    input  logic [9:0]  p2_saber_y_in,
    input  logic [10:0] p2_body_x_in,
    input  logic [9:0]  p2_body_y_in,
    output logic        busy_out,
    output logic        event_valid_out,
    output logic [1:0]  event_code_out,
    output logic [3:0]  p1_score_out,
    output logic [3:0]  p2_score_out,
    output logic        lockout_out,
    output logic        match_over_out
);

    localparam int LCW = (LOCKOUT_FRAMES < 1) ? 1 : $clog2(LOCKOUT_FRAMES + 1);
    localparam logic [11:0]    HIT_R     = 12'(HIT_RADIUS);
    localparam logic [11:0]    PARRY_R   = 12'(PARRY_RADIUS);
    localparam logic [3:0]     WIN       = 4'(WIN_SCORE);
    localparam logic [LCW-1:0] LOCK_LOAD = LCW'(LOCKOUT_FRAMES);

    localparam logic [1:0] CODE_PARRY  = 2'd0;
    localparam logic [1:0] CODE_P1     = 2'd1;
    localparam logic [1:0] CODE_P2     = 2'd2;
    localparam logic [1:0] CODE_DOUBLE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK_CLASH, S_CHK_P1, S_CHK_P2, S_DECIDE, S_LOCKOUT, S_OVER
    } state_t;

    state_t r_state, w_next_state;

    // Latched pose snapshot and per-check results.
    logic [10:0] r_p1_sx, r_p1_bx, r_p2_sx, r_p2_bx;
    logic [9:0]  r_p1_sy, r_p1_by, r_p2_sy, r_p2_by;
    logic        r_p1_blk, r_p2_blk;
    logic        r_clash, r_h1, r_h2;

    // Scores, event outputs and lockout counter.
    logic [3:0]     r_p1_score, r_p2_score;
    logic           r_event_valid;
    logic [1:0]     r_event_code;
    logic [LCW-1:0] r_lock_cnt;

    // Comparator operands and result.
    logic [10:0] w_ax, w_bx, w_dx;
    logic [9:0]  w_ay, w_by, w_dy;
    logic [11:0] w_radius, w_sum;
    logic        w_hit;

    // Decision signals.
    logic       w_v1, w_v2, w_event, w_win;
    logic [1:0] w_code;
    logic [3:0] w_p1_next, w_p2_next;

    // State register.
    always_ff @(posedge clk_pixel_in) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Route the operand pair for the current check into the single comparator.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
        w_ax     = r_p1_sx;
        w_ay     = r_p1_sy;
        w_bx     = r_p2_sx;
        w_by     = r_p2_sy;
        w_radius = PARRY_R;
        case (r_state)
            S_CHK_P1: begin
                w_bx     = r_p2_bx;
                w_by     = r_p2_by;
                w_radius = HIT_R;
            end
            S_CHK_P2: begin
                w_ax     = r_p2_sx;
                w_ay     = r_p2_sy;
                w_bx     = r_p1_bx;
                w_by     = r_p1_by;
                w_radius = HIT_R;
            end
            default: ;
        endcase
    end

    // Larger-minus-smaller keeps the differences unsigned; 11+10 bits fit in 12.
    assign w_dx  = (w_ax >= w_bx) ? (w_ax - w_bx) : (w_bx - w_ax);
    assign w_dy  = (w_ay >= w_by) ? (w_ay - w_by) : (w_by - w_ay);
    assign w_sum = {1'b0, w_dx} + {2'b0, w_dy};
    assign w_hit = (w_sum <= w_radius);

    // A touch is cancelled only when the defender is blocking and the sabers met.
    assign w_v1 = r_h1 & ~(r_p2_blk & r_clash);
    assign w_v2 = r_h2 & ~(r_p1_blk & r_clash);

    // Pick the frame's event from the validated touches and the clash result.
    always_comb begin
        w_event = 1'b0;
        w_code  = CODE_PARRY;
        if (w_v1 && w_v2) begin
            w_event = 1'b1;
            w_code  = CODE_DOUBLE;
        end else if (w_v1) begin
            w_event = 1'b1;
            w_code  = CODE_P1;
        end else if (w_v2) begin
            w_event = 1'b1;
            w_code  = CODE_P2;
        end else if (r_clash && (r_p1_blk || r_p2_blk)) begin
            w_event = 1'b1;
            w_code  = CODE_PARRY;
        end
    end

    assign w_p1_next = (w_event && (w_code == CODE_P1) && (r_p1_score < WIN)) ? r_p1_score + 4'd1 : r_p1_score;
    assign w_p2_next = (w_event && (w_code == CODE_P2) && (r_p2_score < WIN)) ? r_p2_score + 4'd1 : r_p2_score;
    assign w_win     = (w_p1_next >= WIN) || (w_p2_next >= WIN);

    // Next-state sequencing through the checks, decision, lockout and match end.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (new_frame_in) w_next_state = S_CHK_CLASH;
            S_CHK_CLASH: w_next_state = S_CHK_P1;
            S_CHK_P1:    w_next_state = S_CHK_P2;
            S_CHK_P2:    w_next_state = S_DECIDE;
            S_DECIDE: begin
                if (!w_event)                 w_next_state = S_IDLE;
                else if (w_win)               w_next_state = S_OVER;
                else if (LOCKOUT_FRAMES == 0) w_next_state = S_IDLE;
                else                          w_next_state = S_LOCKOUT;
            end
            S_LOCKOUT:   if (new_frame_in && (r_lock_cnt <= LCW'(1))) w_next_state = S_IDLE;
            S_OVER:      w_next_state = S_OVER;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Capture the pose snapshot in IDLE and store each comparator result in its check state.
    always_ff @(posedge clk_pixel_in) begin
        // NOTE: pure datapath registers skip reset; each is written before the FSM ever reads it.
        if (r_state == S_IDLE && new_frame_in) begin
            r_p1_sx  <= p1_saber_x_in;
            r_p1_sy  <= p1_saber_y_in;
            r_p1_bx  <= p1_body_x_in;
            r_p1_by  <= p1_body_y_in;
            r_p2_sx  <= p2_saber_x_in;
            r_p2_sy  <= p2_saber_y_in;
            r_p2_bx  <= p2_body_x_in;
            r_p2_by  <= p2_body_y_in;
            r_p1_blk <= p1_blocking_in;
            r_p2_blk <= p2_blocking_in;
        end
        case (r_state)
            S_CHK_CLASH: r_clash <= w_hit;
            S_CHK_P1:    r_h1    <= w_hit;
            S_CHK_P2:    r_h2    <= w_hit;
            default: ;
        endcase
    end

    // Register the event pulse, scores and lockout countdown.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_event_valid <= 1'b0;
            r_event_code  <= 2'd0;
            r_p1_score    <= 4'd0;
            r_p2_score    <= 4'd0;
            r_lock_cnt    <= '0;
        end else begin
            r_event_valid <= 1'b0;
            if (r_state == S_DECIDE && w_event) begin
                r_event_valid <= 1'b1;
                r_event_code  <= w_code;
                r_p1_score    <= w_p1_next;
                r_p2_score    <= w_p2_next;
            end
            if (r_state == S_DECIDE && w_event && !w_win) begin
                r_lock_cnt <= LOCK_LOAD;
            end else if (r_state == S_LOCKOUT && new_frame_in && (r_lock_cnt != '0)) begin
                r_lock_cnt <= r_lock_cnt - LCW'(1);
            end
        end
    end

    assign busy_out        = (r_state == S_CHK_CLASH) || (r_state == S_CHK_P1) || (r_state == S_CHK_P2) ||
                             (r_state == S_DECIDE)    || (r_state == S_LOCKOUT);
    assign lockout_out     = (r_state == S_LOCKOUT);
    assign match_over_out  = (r_state == S_OVER);
    assign event_valid_out = r_event_valid;
    assign event_code_out  = r_event_code;
    assign p1_score_out    = r_p1_score;
    assign p2_score_out    = r_p2_score;

endmodule

// File: tb/tb_saber_bout_referee.sv
// Testbench for saber_bout_referee: a frame-level referee model predicts every
// output each cycle, and directed scenarios add hand-computed literal checks.
module tb_saber_bout_referee;

    localparam int HIT_R   = 30;
    localparam int PARRY_R = 30;
    localparam int LOCK_N  = 30;
    localparam int WIN_N   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nf  = 1'b0;
    logic        b1  = 1'b0, b2 = 1'b0;
    logic [10:0] p1sx = '0, p1bx = '0, p2sx = '0, p2bx = '0;
    logic [9:0]  p1sy = '0, p1by = '0, p2sy = '0, p2by = '0;
    logic        busy, ev_valid, lockout, over;
    logic [1:0]  ev_code;
    logic [3:0]  s1, s2;

    always #5 clk = ~clk;

    saber_bout_referee #(
        .HIT_RADIUS(HIT_R), .PARRY_RADIUS(PARRY_R), .LOCKOUT_FRAMES(LOCK_N), .WIN_SCORE(WIN_N)
    ) dut (
        .clk_pixel_in(clk), .rst_in(rst), .new_frame_in(nf),
        .p1_blocking_in(b1), .p2_blocking_in(b2),
        .p1_saber_x_in(p1sx), .p1_saber_y_in(p1sy), .p1_body_x_in(p1bx), .p1_body_y_in(p1by),
        .p2_saber_x_in(p2sx), .p2_saber_y_in(p2sy), .p2_body_x_in(p2bx), .p2_body_y_in(p2by),
        .busy_out(busy), .event_valid_out(ev_valid), .event_code_out(ev_code),
        .p1_score_out(s1), .p2_score_out(s2), .lockout_out(lockout), .match_over_out(over)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Frame-level referee model ----------------
    // Frame evaluation is a 4-edge delay after the accepting strobe, lockout is a
    // count of remaining strobes, and the match is over once a score hits WIN_N.
    int m_cd = 0, m_lock = 0, m_p1 = 0, m_p2 = 0, m_code = 0, m_pend_code = 0;
    bit m_over = 0, m_valid = 0, m_pend_ev = 0;
    bit mc_clash, mc_h1, mc_h2, mc_v1, mc_v2;

    function automatic int mdist(input int ax, input int ay, input int bx, input int by);
        int dx, dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return dx + dy;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cd = 0; m_lock = 0; m_p1 = 0; m_p2 = 0; m_code = 0;
            m_over = 0; m_valid = 0; m_pend_ev = 0;
        end else begin
            m_valid = 0;
            if (m_over) begin
                // match finished: nothing changes until reset
            end else if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0 && m_pend_ev) begin
                    m_valid = 1;
                    m_code  = m_pend_code;
                    if (m_pend_code == 1 && m_p1 < WIN_N) m_p1++;
                    if (m_pend_code == 2 && m_p2 < WIN_N) m_p2++;
                    if (m_p1 >= WIN_N || m_p2 >= WIN_N) m_over = 1;
                    else                                 m_lock = LOCK_N;
                end
            end else if (m_lock > 0) begin
                if (nf) m_lock--;
            end else if (nf) begin
                mc_clash = mdist(p1sx, p1sy, p2sx, p2sy) <= PARRY_R;
                mc_h1    = mdist(p1sx, p1sy, p2bx, p2by) <= HIT_R;
                mc_h2    = mdist(p2sx, p2sy, p1bx, p1by) <= HIT_R;
                mc_v1    = mc_h1 && !(b2 && mc_clash);
                mc_v2    = mc_h2 && !(b1 && mc_clash);
                m_pend_ev = 1;
                if (mc_v1 && mc_v2)                m_pend_code = 3;
                else if (mc_v1)                    m_pend_code = 1;
                else if (mc_v2)                    m_pend_code = 2;
                else if (mc_clash && (b1 || b2))   m_pend_code = 0;
                else                               m_pend_ev = 0;
                m_cd = 4;
            end
        end
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("event_valid", 32'(ev_valid), 32'(m_valid));
            check("event_code",  32'(ev_code),  32'(m_code));
            check("p1_score",    32'(s1),       32'(m_p1));
            check("p2_score",    32'(s2),       32'(m_p2));
            check("busy",        32'(busy),     32'((m_cd > 0) || (m_lock > 0)));
            check("lockout",     32'(lockout),  32'(m_lock > 0));
            check("match_over",  32'(over),     32'(m_over));
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pose(input int a_sx, input int a_sy, input int a_bx, input int a_by,
                        input int c_sx, input int c_sy, input int c_bx, input int c_by,
                        input bit blk1, input bit blk2);
        p1sx = 11'(a_sx); p1sy = 10'(a_sy); p1bx = 11'(a_bx); p1by = 10'(a_by);
        p2sx = 11'(c_sx); p2sy = 10'(c_sy); p2bx = 11'(c_bx); p2by = 10'(c_by);
        b1 = blk1; b2 = blk2;
    endtask

    task automatic frame();
        nf = 1'b1;
        tick();
        nf = 1'b0;
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            nf = 1'b1;
            tick();
            nf = 1'b0;
            tick();
        end
    endtask

    // Called right after frame(): the pulse lands on the 4th following edge.
    task automatic expect_event(input string tag, input int code, input int e1, input int e2);
        repeat (4) tick();
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_code"},  32'(ev_code),  32'(code));
        check({tag, "_p1"},    32'(s1),       32'(e1));
        check({tag, "_p2"},    32'(s2),       32'(e2));
        tick();
        check({tag, "_pulse_end"}, 32'(ev_valid), 32'd0);
    endtask

    // ---------------- Directed scenarios ----------------
    initial begin
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_p1", 32'(s1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_over", 32'(over), 32'd0);

        // Clean P1 touch (distance 25); inputs scrambled after latching.
        pose(100, 100, 600, 400, 300, 100, 120, 105, 0, 0);
        frame();
        pose(100, 100, 600, 400, 600, 400, 120, 105, 0, 0);
        expect_event("touch", 1, 1, 0);
        check("touch_lockout", 32'(lockout), 32'd1);
        pose(100, 100, 600, 400, 300, 100, 120, 105, 0, 0);
        strobes(29);
        check("lock29_still", 32'(lockout), 32'd1);
        strobes(1);
        check("lock30_exit", 32'(lockout), 32'd0);
        repeat (6) tick();
        check("lock30_not_eval", 32'(s1), 32'd1);
        check("lock30_idle", 32'(busy), 32'd0);

        // Parry: sabers 20 apart, P2 blocking cancels P1 touch.
        pose(100, 100, 600, 400, 110, 110, 120, 105, 0, 1);
        frame();
        expect_event("parry", 0, 1, 0);
        check("parry_lockout", 32'(lockout), 32'd1);
        strobes(30);

        // Hit radius boundary: exactly 30 (saber beyond body) touches.
        pose(100, 100, 600, 400, 300, 100, 80, 90, 0, 0);
        frame();
        expect_event("hit30", 1, 2, 0);
        strobes(30);

        // Distance 31: nothing happens, straight back to IDLE.
        pose(100, 100, 600, 400, 300, 100, 120, 111, 0, 0);
        frame();
        repeat (4) tick();
        check("hit31_valid", 32'(ev_valid), 32'd0);
        tick();
        check("hit31_busy", 32'(busy), 32'd0);
        check("hit31_lockout", 32'(lockout), 32'd0);

        // Clash radius boundary: 30 -> parry, 31 -> touch goes through.
        pose(100, 100, 600, 400, 120, 110, 120, 105, 0, 1);
        frame();
        expect_event("clash30", 0, 2, 0);
        strobes(30);
        pose(100, 100, 600, 400, 121, 110, 120, 105, 0, 1);
        frame();
        expect_event("clash31", 1, 3, 0);
        strobes(30);

        // Double touch: no score change.
        pose(100, 100, 510, 310, 500, 300, 120, 105, 0, 0);
        frame();
        expect_event("double", 3, 3, 0);
        strobes(30);

        // Extreme coordinates: large distances, no event.
        pose(2047, 1023, 2047, 1023, 0, 0, 0, 0, 1, 1);
        frame();
        repeat (5) tick();
        check("extreme_busy", 32'(busy), 32'd0);

        // P2 touch with P1 blocking but no clash: touch stands.
        pose(100, 100, 510, 310, 500, 300, 900, 500, 1, 0);
        frame();
        expect_event("p2touch", 2, 3, 1);
        strobes(30);

        // Extra strobe during checks is dropped.
        frame();
        nf = 1'b1;
        tick();
        nf = 1'b0;
        repeat (3) tick();
        check("extra_valid", 32'(ev_valid), 32'd1);
        check("extra_p2", 32'(s2), 32'd2);
        tick();
        strobes(30);
        repeat (6) tick();
        check("extra_not_queued", 32'(busy), 32'd0);

        // Reset during CHK_P1.
        pose(100, 100, 600, 400, 300, 100, 120, 105, 0, 0);
        frame();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_code", 32'(ev_code), 32'd0);
        check("midrst_p2", 32'(s2), 32'd0);
        repeat (6) tick();
        check("midrst_no_event", 32'(s1), 32'd0);

        // Match end: five P1 touches.
        for (int i = 1; i <= WIN_N; i++) begin
            frame();
            expect_event("match", 1, i, 0);
            if (i < WIN_N) strobes(LOCK_N);
        end
        check("match_over", 32'(over), 32'd1);
        check("match_busy", 32'(busy), 32'd0);
        check("match_lockout", 32'(lockout), 32'd0);
        repeat (3) begin
            frame();
            repeat (6) tick();
        end
        check("over_p1_hold", 32'(s1), 32'd5);
        check("over_hold", 32'(over), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("final_rst_p1", 32'(s1), 32'd0);
        check("final_rst_over", 32'(over), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
